// File: rtl/memory_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : memory_sequencer
//  Description : Single-port word RAM behind a request/complete handshake.
//                A request is captured in IDLE, held through WAIT_CYCLES wait
//                states, performed in ACCESS and reported with a one-cycle
//                done pulse. Out-of-range addresses complete with addr_err.
//                Status outputs are registered from the FSM state, so the
//                done pulse is seen WAIT_CYCLES+2 edges after the accept edge.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_sequencer #(
    parameter int DEPTH       = 512,
    parameter int ADDR_BITS   = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] MAR,
    input  logic [31:0] MDRout,
    output logic [31:0] Mdatain,
    output logic        busy,
    output logic        done,
    output logic        addr_err
);

    localparam logic [3:0]  c_wait_init = 4'(WAIT_CYCLES);
    localparam logic [31:0] c_depth     = 32'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   is_read_q, is_read_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [31:0]            data_q, data_d;
    logic                   err_q, err_d;

    logic [31:0]            mdata_q, mdata_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   aerr_q, aerr_d;

    logic                   w_accept;
    logic                   w_do_write;

    // RAM starts at zero and is never touched by clear.
    logic [31:0] mem_q [DEPTH] = '{default: '0};

    // busy_q also covers the done cycle, so a new request is refused until
    // the completion pulse has been seen.
    assign w_accept   = (state_q == S_IDLE) && !busy_q && (read || write);
    assign w_do_write = (state_q == S_ACCESS) && !is_read_q && !err_q;

    // Next-state, request capture and registered-output next values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_read_d = is_read_q;
        idx_d     = idx_q;
        data_d    = data_q;
        err_d     = err_q;
        mdata_d   = mdata_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    // A simultaneous read and write is treated as a read.
                    is_read_d = read;
                    idx_d     = MAR[ADDR_BITS-1:0];
                    data_d    = MDRout;
                    err_d     = (MAR >= c_depth);
                    cnt_d     = c_wait_init;
                    state_d   = (c_wait_init != 4'd0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                if (is_read_q && !err_q) begin
                    mdata_d = mem_q[idx_q];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
        done_d = (state_q == S_DONE);
        aerr_d = (state_q == S_DONE) && err_q;
    end

    // FSM, captured request and output registers; clear overrides everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            is_read_q <= 1'b0;
            idx_q     <= '0;
            data_q    <= 32'd0;
            err_q     <= 1'b0;
            mdata_q   <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_read_q <= is_read_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            err_q     <= err_d;
            mdata_q   <= mdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aerr_q    <= aerr_d;
        end
    end

    // RAM write at the closing edge of ACCESS; a clear on that edge aborts it.
    always_ff @(posedge clock) begin
        if (!clear && w_do_write) begin
            mem_q[idx_q] <= data_q;
        end
    end

    assign Mdatain  = mdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign addr_err = aerr_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_sequencer
//  Description : Directed bench for memory_sequencer; instance A uses two
//                wait states, instance B uses none.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        a_read, a_write, b_read, b_write;
    logic [31:0] a_mar, a_mdr, b_mar, b_mdr;
    wire  [31:0] a_mdat, b_mdat;
    wire         a_busy, a_done, a_err, b_busy, b_done, b_err;

    int n_tests = 0;
    int n_fail  = 0;

    int          lat, npulse;
    logic [31:0] dout;
    logic        aerr, busy1;

    always #5 clock = ~clock;

    memory_sequencer #(.DEPTH(512), .ADDR_BITS(9), .WAIT_CYCLES(2)) u_dut_a (
        .clock(clock), .clear(clear), .read(a_read), .write(a_write),
        .MAR(a_mar), .MDRout(a_mdr), .Mdatain(a_mdat),
        .busy(a_busy), .done(a_done), .addr_err(a_err)
    );

    memory_sequencer #(.DEPTH(512), .ADDR_BITS(9), .WAIT_CYCLES(0)) u_dut_b (
        .clock(clock), .clear(clear), .read(b_read), .write(b_write),
        .MAR(b_mar), .MDRout(b_mdr), .Mdatain(b_mdat),
        .busy(b_busy), .done(b_done), .addr_err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request; lat = index of the first negedge after the accept edge
    // where done is high (0 if none within the window).
    task automatic txn(input bit z, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data,
                       input bit disturb,
                       output int o_lat, output int o_npulse,
                       output logic [31:0] o_dout, output logic o_aerr,
                       output logic o_busy1);
        @(negedge clock);
        if (z) begin
            b_read = rd; b_write = wr; b_mar = addr; b_mdr = data;
        end else begin
            a_read = rd; a_write = wr; a_mar = addr; a_mdr = data;
        end
        @(posedge clock); #1;
        a_read = 1'b0; a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
        o_lat = 0; o_npulse = 0; o_dout = 32'd0; o_aerr = 1'b0; o_busy1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (disturb && k == 1) begin
                a_write = 1'b1; a_mar = 32'd9; a_mdr = 32'hBAD0BAD0;
            end else if (disturb && k == 2) begin
                a_write = 1'b0; a_read = 1'b1; a_mar = 32'd10; a_mdr = 32'h11111111;
            end else begin
                a_read = 1'b0; a_write = 1'b0;
            end
            @(negedge clock);
            if (k == 1) o_busy1 = z ? b_busy : a_busy;
            if ((z ? b_done : a_done) === 1'b1) begin
                o_npulse++;
                if (o_lat == 0) begin
                    o_lat  = k;
                    o_dout = z ? b_mdat : a_mdat;
                    o_aerr = z ? b_err : a_err;
                end
            end
            @(posedge clock); #1;
        end
    endtask

    initial begin
        clear = 1'b1;
        a_read = 1'b0; a_write = 1'b0; a_mar = 32'd0; a_mdr = 32'd0;
        b_read = 1'b0; b_write = 1'b0; b_mar = 32'd0; b_mdr = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_done", {31'd0, a_done}, 32'd0);
        check("rst_aerr", {31'd0, a_err}, 32'd0);
        check("rst_mdat", a_mdat, 32'd0);
        clear = 1'b0;

        // Write then read back; done 4 edges after accept -> 5th negedge.
        txn(0, 1, 0, 32'd0, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        check("rd_init0", dout, 32'd0);
        txn(0, 0, 1, 32'd5, 32'hDEADBEEF, 0, lat, npulse, dout, aerr, busy1);
        check("wr5_lat", lat, 5);
        check("wr5_pulses", npulse, 1);
        check("wr5_aerr", {31'd0, aerr}, 32'd0);
        check("wr5_busy", {31'd0, busy1}, 32'd1);
        check("wr5_mdat", dout, 32'd0);
        txn(0, 1, 0, 32'd5, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        check("rd5_lat", lat, 5);
        check("rd5_data", dout, 32'hDEADBEEF);
        check("rd5_aerr", {31'd0, aerr}, 32'd0);

        // Simultaneous strobes perform a read only.
        txn(0, 1, 1, 32'd5, 32'h1, 0, lat, npulse, dout, aerr, busy1);
        check("both_data", dout, 32'hDEADBEEF);
        check("both_lat", lat, 5);
        txn(0, 1, 0, 32'd5, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        check("both_ram5", dout, 32'hDEADBEEF);

        // Top in-range address.
        txn(0, 0, 1, 32'd511, 32'h600DF00D, 0, lat, npulse, dout, aerr, busy1);
        check("wr511_aerr", {31'd0, aerr}, 32'd0);
        txn(0, 1, 0, 32'd511, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        check("rd511_data", dout, 32'h600DF00D);

        // Out-of-range accesses.
        txn(0, 1, 0, 32'd5, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        txn(0, 0, 1, 32'h200, 32'h55, 0, lat, npulse, dout, aerr, busy1);
        check("oor_wr_aerr", {31'd0, aerr}, 32'd1);
        check("oor_wr_lat", lat, 5);
        check("oor_wr_mdat", dout, 32'hDEADBEEF);
        txn(0, 1, 0, 32'h200, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        check("oor_rd_aerr", {31'd0, aerr}, 32'd1);
        check("oor_rd_mdat", dout, 32'hDEADBEEF);
        txn(0, 0, 1, 32'h80000005, 32'h77, 0, lat, npulse, dout, aerr, busy1);
        check("oor_hi_aerr", {31'd0, aerr}, 32'd1);
        txn(0, 1, 0, 32'd5, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        check("oor_hi_ram5", dout, 32'hDEADBEEF);
        txn(0, 1, 0, 32'd0, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        check("oor_ram0", dout, 32'd0);
        check("oor_ram0_aerr", {31'd0, aerr}, 32'd0);

        // Strobes and address changes during WAIT are ignored.
        txn(0, 1, 0, 32'd5, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        txn(0, 0, 1, 32'd3, 32'hCAFE0003, 1, lat, npulse, dout, aerr, busy1);
        check("busy_pulses", npulse, 1);
        check("busy_lat", lat, 5);
        check("busy_mdat", dout, 32'hDEADBEEF);
        txn(0, 1, 0, 32'd3, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        check("busy_ram3", dout, 32'hCAFE0003);
        txn(0, 1, 0, 32'd9, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        check("busy_ram9", dout, 32'd0);
        txn(0, 1, 0, 32'd5, 32'd0, 0, lat, npulse, dout, aerr, busy1);

        // Clear during WAIT aborts a write.
        @(negedge clock);
        a_write = 1'b1; a_mar = 32'd7; a_mdr = 32'h1234;
        @(posedge clock); #1;
        a_write = 1'b0; clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
        @(negedge clock);
        check("clr_busy", {31'd0, a_busy}, 32'd0);
        check("clr_done", {31'd0, a_done}, 32'd0);
        check("clr_mdat", a_mdat, 32'd0);
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (a_done === 1'b1) npulse++;
        end
        check("clr_no_done", npulse, 0);
        txn(0, 1, 0, 32'd7, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        check("clr_ram7", dout, 32'd0);

        // Zero-wait instance: done 2 edges after accept -> 3rd negedge.
        txn(1, 0, 1, 32'd5, 32'hA5A5A5A5, 0, lat, npulse, dout, aerr, busy1);
        check("zw_wr_lat", lat, 3);
        txn(1, 1, 0, 32'd5, 32'd0, 0, lat, npulse, dout, aerr, busy1);
        check("zw_rd_lat", lat, 3);
        check("zw_rd_data", dout, 32'hA5A5A5A5);
        check("zw_rd_pulses", npulse, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_sequencer.md
MEMORY_SEQUENCER -- requirements
Module: memory_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 512: number of 32-bit words in the internal RAM.
REQ-002 SHALL have parameter ADDR_BITS, default 9: RAM index width, equal to log2(DEPTH).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, legal range 0-15: wait states inserted before each access.
REQ-004 SHALL have port clock  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port clear  input  1: reset; synchronous, active-high.
REQ-006 SHALL have port read  input  1: read request strobe.
REQ-007 SHALL have port write  input  1: write request strobe.
REQ-008 SHALL have port MAR  input  32: word address of the access.
REQ-009 SHALL have port MDRout  input  32: write data.
REQ-010 SHALL have port Mdatain  output  32: read data, driven to the MDR input mux.
REQ-011 SHALL have port busy  output  1: high while a request is in progress.
REQ-012 SHALL have port done  output  1: one-cycle completion pulse.
REQ-013 SHALL have port addr_err  output  1: out-of-range flag, valid while done=1.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACCESS and DONE; all outputs SHALL be registered.
REQ-015 In IDLE, at a rising edge with read=1 or write=1, SHALL accept the request and capture MAR, MDRout and the operation type into internal registers.
- Later changes on MAR, MDRout, read or write SHALL NOT affect the request in flight.
REQ-016 If read=1 and write=1 at the accept edge, SHALL perform a read; the write SHALL be discarded.
REQ-017 On accept, SHALL load the wait counter with WAIT_CYCLES.
- Next state SHALL be WAIT if WAIT_CYCLES>0, otherwise ACCESS.
REQ-018 WAIT SHALL decrement the counter each cycle and move to ACCESS on the edge where the counter reaches 0; WAIT therefore lasts exactly WAIT_CYCLES cycles.
REQ-019 ACCESS SHALL last one cycle; at its closing edge the RAM operation is performed:
- read: Mdatain <= RAM[captured address].
- write: RAM[captured address] <= captured data.
REQ-020 DONE SHALL last one cycle with done=1; next state SHALL be IDLE.
REQ-021 Latency: if the accept edge is edge E0, done SHALL be high during the cycle following edge E0+WAIT_CYCLES+2; back-to-back requests SHALL be accepted no earlier than the edge ending DONE.
REQ-022 busy SHALL be 1 in WAIT, ACCESS and DONE, and 0 in IDLE.
REQ-023 read/write asserted while busy=1 SHALL be ignored; they are neither queued nor counted.
REQ-024 Out-of-range address (captured MAR >= DEPTH, judged on all 32 bits): SHALL run the same state sequence with the same latency, perform no RAM access, leave Mdatain unchanged, and assert addr_err=1 together with done.
REQ-025 addr_err SHALL be 0 whenever done=0.
REQ-026 Mdatain SHALL hold its value until the next successful read completes; writes SHALL NOT alter Mdatain.
REQ-027 RAM contents SHALL be initialised to zero at time 0.

Reset
REQ-028 clear=1 at a rising edge SHALL force state IDLE, busy=0, done=0, addr_err=0, Mdatain=0 and wait counter=0, overriding all other inputs.
REQ-029 clear during WAIT or ACCESS SHALL abort the request; the pending RAM write SHALL NOT occur.
REQ-030 RAM contents SHALL NOT be changed by clear.
REQ-031 A request with clear=1 at the same edge SHALL NOT be accepted.

Verification (WAIT_CYCLES=2)
REQ-032 Write then read:
- Stimulus: write, MAR=5, MDRout=0xDEADBEEF; after done, read MAR=5.
- Required: done exactly 4 cycles after each accept edge; Mdatain=0xDEADBEEF at the second done; addr_err=0 both times.
REQ-033 Simultaneous strobes:
- Stimulus: read=1, write=1, MAR=5, MDRout=0x1.
- Required: read performed; Mdatain=0xDEADBEEF; RAM[5] unchanged on a subsequent read.
REQ-034 Out-of-range access:
- Stimulus: write MAR=0x200 (=DEPTH) with data 0x55, then read MAR=0x200.
- Required: done with addr_err=1 both times; Mdatain unchanged; RAM[0]=0 on a later read of address 0.
REQ-035 Requests while busy:
- Stimulus: toggle read/write and change MAR/MDRout during WAIT.
- Required: only the originally accepted request completes; exactly one done pulse.
REQ-036 Reset mid-write:
- Stimulus: write MAR=7, data 0x1234; clear=1 during WAIT.
- Required: busy=0, done=0 and Mdatain=0 next cycle; a subsequent read of MAR=7 returns 0.
REQ-037 Zero-wait build:
- Stimulus: WAIT_CYCLES=0; read MAR=5 after a write of 0xA5A5A5A5 to MAR=5.
- Required: done 2 cycles after the accept edge; Mdatain=0xA5A5A5A5.
